// File: rtl/prog_ctrl_pkg.sv
// Shared encodings and default sizing for the load/run/dump controller.
// The CPU bench imports this to decode the controller state.
package prog_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_PAD     = 3'd2,
        ST_WARMUP  = 3'd3,
        ST_RUN     = 3'd4,
        ST_DUMP_RD = 3'd5,
        ST_DUMP_TX = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_WORD_BYTES = 4;
    localparam int DEF_WARMUP_CYC = 4;
    localparam int DEF_RUN_MAX    = 1024;
    localparam int DEF_DUMP_BASE  = 0;
    localparam int DEF_DUMP_LEN   = 256;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dump_out_reg.sv
// Valid/ready holding register for the dump byte stream; data and last stay
// stable from load until the consumer accepts.
module dump_out_reg (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       last_in,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] dout,
    output logic       last
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            valid <= 1'b0;
            dout  <= 8'h00;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
            last  <= last_in;
        end else if (valid && ready) begin
            // dout is left holding the accepted byte; only the qualifiers drop
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule

// File: rtl/prog_load_dump_ctrl.sv
// Load/run/dump sequencer: streams a host image into RAM, runs the CPU through a
// warm-up window up to a cycle limit, then streams a RAM window back out.
//
// state      | meaning
// IDLE       | waiting for start after reset
// LOAD       | accepting image bytes, one write per handshake
// PAD        | zero-filling up to the next word boundary
// WARMUP     | CPU released, halt ignored for WARMUP_CYC cycles
// RUN        | CPU running until halt or RUN_MAX cycles
// DUMP_RD    | presenting the dump address to the RAM
// DUMP_TX    | capturing the read byte and holding it until accepted
// DONE       | sequence complete, waiting for start
module prog_load_dump_ctrl
    import prog_ctrl_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int WORD_BYTES = DEF_WORD_BYTES,
    parameter int WARMUP_CYC = DEF_WARMUP_CYC,
    parameter int RUN_MAX    = DEF_RUN_MAX,
    parameter int DUMP_BASE  = DEF_DUMP_BASE,
    parameter int DUMP_LEN   = DEF_DUMP_LEN
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              cpu_run,
    input  logic              cpu_halt,
    output logic              dp_valid,
    input  logic              dp_ready,
    output logic [7:0]        dp_data,
    output logic              dp_last,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              overflow,
    output logic [ADDR_W-1:0] word_count
);

    localparam int WARM_W = cnt_width(WARMUP_CYC);
    localparam int RUN_W  = cnt_width(RUN_MAX);

    // WORD_BYTES is a power of two, so alignment is a mask test on the pointer.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] PTR_MAX    = '1;
    localparam logic [ADDR_W-1:0] DUMP_LAST  = ADDR_W'(DUMP_LEN - 1);
    localparam logic [ADDR_W-1:0] DUMP_BASEA = ADDR_W'(DUMP_BASE);
    localparam logic [WARM_W-1:0] WARM_LAST  = WARM_W'(WARMUP_CYC - 1);
    localparam logic [RUN_W-1:0]  RUN_LAST   = RUN_W'(RUN_MAX - 1);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   ptr, ptr_nxt;
    logic [ADDR_W-1:0]   wc;
    logic                timeout_q, overflow_q;
    logic [WARM_W-1:0]   warm_cnt;
    logic [RUN_W-1:0]    run_cnt;
    logic [ADDR_W-1:0]   dump_idx;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [7:0]          wr_data_q;

    logic                load_go, wr_en, ovf_set, to_set, dump_load, dump_hs;
    logic [7:0]          wr_byte;

    assign ptr_nxt = ptr + ADDR_W'(1);

    always_comb begin
        state_n   = state;
        ld_ready  = 1'b0;
        cpu_run   = 1'b0;
        wr_en     = 1'b0;
        wr_byte   = 8'h00;
        load_go   = 1'b0;
        ovf_set   = 1'b0;
        to_set    = 1'b0;
        dump_load = 1'b0;
        dump_hs   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load_go = 1'b1;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    wr_en   = 1'b1;
                    wr_byte = ld_data;
                    ovf_set = (ptr == PTR_MAX) && !ld_last;
                    if (ld_last || ptr == PTR_MAX)
                        state_n = ((ptr_nxt & ALIGN_MASK) == '0) ? ST_WARMUP : ST_PAD;
                end
            end
            ST_PAD: begin
                wr_en = 1'b1;
                if ((ptr_nxt & ALIGN_MASK) == '0)
                    state_n = ST_WARMUP;
            end
            ST_WARMUP: begin
                cpu_run = 1'b1;
                if (warm_cnt == '0)
                    state_n = ST_RUN;
            end
            ST_RUN: begin
                cpu_run = 1'b1;
                // halt on the last allowed cycle wins over the limit
                if (cpu_halt) begin
                    state_n = ST_DUMP_RD;
                end else if (run_cnt == RUN_LAST) begin
                    to_set  = 1'b1;
                    state_n = ST_DUMP_RD;
                end
            end
            ST_DUMP_RD: state_n = ST_DUMP_TX;
            ST_DUMP_TX: begin
                if (!dp_valid) begin
                    dump_load = 1'b1;
                end else if (dp_ready) begin
                    dump_hs = 1'b1;
                    state_n = (dump_idx == DUMP_LAST) ? ST_DONE : ST_DUMP_RD;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            wc         <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            warm_cnt   <= '0;
            run_cnt    <= '0;
            dump_idx   <= '0;
            mem_we_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
        end else begin
            state    <= state_n;
            mem_we_q <= wr_en;
            if (load_go) begin
                ptr        <= '0;
                wc         <= '0;
                timeout_q  <= 1'b0;
                overflow_q <= 1'b0;
            end
            if (wr_en) begin
                ptr       <= ptr_nxt;
                wr_addr_q <= ptr;
                wr_data_q <= wr_byte;
                if ((ptr & ALIGN_MASK) == ALIGN_MASK)
                    wc <= wc + ADDR_W'(1);
            end
            if (ovf_set)
                overflow_q <= 1'b1;
            if (to_set)
                timeout_q <= 1'b1;
            if (state != ST_WARMUP)
                warm_cnt <= WARM_LAST;
            else if (warm_cnt != '0)
                warm_cnt <= warm_cnt - WARM_W'(1);
            if (state != ST_RUN)
                run_cnt <= '0;
            else
                run_cnt <= run_cnt + RUN_W'(1);
            if (state == ST_RUN)
                dump_idx <= '0;
            else if (dump_hs)
                dump_idx <= dump_idx + ADDR_W'(1);
        end
    end

    dump_out_reg u_dump_out_reg (
        .clk     (clk),
        .clr     (clr),
        .load    (dump_load),
        .din     (mem_rdata),
        .last_in (dump_idx == DUMP_LAST),
        .ready   (dp_ready),
        .valid   (dp_valid),
        .dout    (dp_data),
        .last    (dp_last)
    );

    assign mem_we     = mem_we_q;
    assign mem_wdata  = wr_data_q;
    assign mem_addr   = (state == ST_DUMP_RD || state == ST_DUMP_TX) ? (DUMP_BASEA + dump_idx)
                                                                     : wr_addr_q;
    assign busy       = (state != ST_IDLE) && (state != ST_DONE);
    assign done       = (state == ST_DONE);
    assign timeout    = timeout_q;
    assign overflow   = overflow_q;
    assign word_count = wc;

endmodule

// File: tb/tb_prog_load_dump_ctrl.sv
// Bench for prog_load_dump_ctrl: RAM and CPU-halt models, sequence table, and
// hand-written reset sequences.
module tb_prog_load_dump_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       start, ld_valid, ld_ready, ld_last;
    logic [7:0] ld_data;
    logic       mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       cpu_run, cpu_halt;
    logic       dp_valid, dp_ready, dp_last;
    logic [7:0] dp_data;
    logic       busy, done, timeout, overflow;
    logic [7:0] word_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_load_dump_ctrl #(
        .ADDR_W(8), .WORD_BYTES(4), .WARMUP_CYC(4),
        .RUN_MAX(16), .DUMP_BASE(0), .DUMP_LEN(256)
    ) dut (
        .clk(clk), .clr(clr), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_run(cpu_run), .cpu_halt(cpu_halt),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_data(dp_data), .dp_last(dp_last),
        .busy(busy), .done(done), .timeout(timeout), .overflow(overflow),
        .word_count(word_count)
    );

    // Byte RAM with one-cycle read latency; preset to a non-zero pattern.
    logic [7:0] ram [256];
    logic       ram_init;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'hA5 ^ 8'(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Write log, owned by this process only.
    logic [7:0] wlog_addr [4096];
    logic [7:0] wlog_data [4096];
    int         wr_seen = 0;
    always @(negedge clk) begin
        if (mem_we) begin
            wlog_addr[wr_seen % 4096] = mem_addr;
            wlog_data[wr_seen % 4096] = mem_wdata;
            wr_seen++;
        end
    end

    typedef struct {
        int n_bytes;  bit use_last; int halt_at; bit halt_warm; bit start_mid; bit stall;
        int exp_acc;  int exp_len;  int exp_wc;  int exp_run;   bit exp_to;    bit exp_ovf;
    } vec_t;

    vec_t       tbl [7];
    logic [7:0] img0 [8];
    logic [7:0] exp_ram [256];
    logic [7:0] exp_img [256];
    int         exp_len;
    int         wr_base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] img_byte(input int s, input int i);
        logic [31:0] t;
        if (s == 0) return img0[i % 8];
        t = s * 37 + i * 11 + 5;
        return t[7:0];
    endfunction

    task automatic prep_image(input int s, input int acc, input int len);
        exp_len = len;
        for (int i = 0; i < len; i++) begin
            exp_img[i] = (i < acc) ? img_byte(s, i) : 8'h00;
            exp_ram[i] = exp_img[i];
        end
        wr_base = wr_seen;
    endtask

    task automatic check_writes();
        int n;
        n = wr_seen - wr_base;
        chk("wr_count", n, exp_len);
        for (int i = 0; i < n && i < exp_len; i++) begin
            chk("wr_addr", wlog_addr[(wr_base + i) % 4096], i);
            chk("wr_data", wlog_data[(wr_base + i) % 4096], exp_img[i]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ld_ready_on_load", ld_ready, 1);
        chk("busy_on_load", busy, 1);
    endtask

    task automatic load_bytes(input int s, input int n, input bit use_last, output int acc);
        acc = 0;
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = img_byte(s, i);
            ld_last  = use_last && (i == n - 1);
            if (!ld_ready) break;
            @(negedge clk);
            acc++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic run_seq(input vec_t v, input int s);
        int acc, run_seen, dumped, last_cnt, first_v, last_run, stall_left;
        bit got_done;
        prep_image(s, v.exp_acc, v.exp_len);
        pulse_start();
        load_bytes(s, v.n_bytes, v.use_last, acc);
        chk("accepted", acc, v.exp_acc);
        run_seen = 0; dumped = 0; last_cnt = 0; first_v = -1; last_run = -1;
        stall_left = v.stall ? 5 : 0;
        got_done = 0;
        for (int c = 0; c < 3000; c++) begin
            if (cpu_run) begin
                run_seen++;
                last_run = c;
            end
            cpu_halt = cpu_run && ((v.halt_at != 0 && run_seen == v.halt_at) ||
                                   (v.halt_warm && run_seen == 2));
            start    = v.start_mid && cpu_run && (run_seen == 8);
            dp_ready = 1'b1;
            if (dp_valid) begin
                if (first_v < 0) first_v = c;
                chk("dp_last", dp_last, (dumped == 255));
                if (stall_left > 0 && dumped == 100) begin
                    dp_ready = 1'b0;
                    stall_left--;
                    chk("stall_data", dp_data, exp_ram[100]);
                end else begin
                    chk("dp_data", dp_data, exp_ram[dumped % 256]);
                    if (dp_last) last_cnt++;
                    dumped++;
                end
            end
            if (done) begin
                got_done = 1;
                break;
            end
            @(negedge clk);
        end
        cpu_halt = 1'b0;
        start    = 1'b0;
        chk("done_reached", got_done, 1);
        chk("cpu_run_cycles", run_seen, v.exp_run);
        chk("dump_bytes", dumped, 256);
        chk("dp_last_count", last_cnt, 1);
        chk("first_valid_lat", first_v - last_run, 3);
        chk("word_count", word_count, v.exp_wc);
        chk("timeout", timeout, v.exp_to);
        chk("overflow", overflow, v.exp_ovf);
        chk("busy_done", busy, 0);
        chk("cpu_run_done", cpu_run, 0);
        check_writes();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ld_ready"}, ld_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_cpu_run"}, cpu_run, 0);
        chk({tag, "_dp_valid"}, dp_valid, 0);
        chk({tag, "_dp_data"}, dp_data, 0);
        chk({tag, "_dp_last"}, dp_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_word_count"}, word_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, run_seen;
        img0 = '{8'hE3, 8'hA0, 8'h10, 8'h04, 8'hE2, 8'h81, 8'h10, 8'h08};
        //          n   last halt  hw  sm  st   acc  len  wc  run to ovf
        tbl[0] = '{  8, 1,   14,   0,  0,  0,     8,   8,  2, 14, 0, 0};
        tbl[1] = '{  6, 1,   12,   0,  0,  1,     6,   8,  2, 12, 0, 0};
        tbl[2] = '{ 12, 1,    0,   0,  1,  0,    12,  12,  3, 20, 1, 0};
        tbl[3] = '{  5, 1,    9,   1,  0,  0,     5,   8,  2,  9, 0, 0};
        tbl[4] = '{  7, 1,   20,   0,  0,  0,     7,   8,  2, 20, 0, 0};
        tbl[5] = '{300, 0,   10,   0,  0,  0,   256, 256, 64, 10, 0, 1};
        tbl[6] = '{  3, 1,    6,   0,  0,  0,     3,   4,  1,  6, 0, 0};
        for (int i = 0; i < 256; i++) exp_ram[i] = 8'hA5 ^ 8'(i);

        clr = 1'b0; ram_init = 1'b1;
        start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h00;
        cpu_halt = 1'b0; dp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        ram_init = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", busy, 0);

        for (int t = 0; t < 7; t++) begin
            run_seq(tbl[t], t);
            chk("done_level", done, 1);
        end

        // Asynchronous reset in the middle of RUN.
        prep_image(9, 4, 4);
        pulse_start();
        load_bytes(9, 4, 1'b1, acc);
        run_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (cpu_run) run_seen++;
            if (run_seen == 7) break;
            @(negedge clk);
        end
        chk("rst_reach_run", run_seen, 7);
        chk("rst_pre_cpu_run", cpu_run, 1);
        chk("rst_pre_word_count", word_count, 1);
        chk("rst_pre_mem_addr", mem_addr, 3);
        #2 clr = 1'b0;
        #1 check_all_zero("midrun");
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("rst_post_busy", busy, 0);
        chk("rst_post_done", done, 0);
        chk("rst_post_cpu_run", cpu_run, 0);
        check_writes();

        // Recovery from IDLE after the mid-run reset.
        run_seq(tbl[6], 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_load_dump_ctrl.md
# prog_load_dump_ctrl

- Synthesisable run controller for the ARM CPU bring-up flow. It streams a byte image into the byte-addressed RAM and holds the CPU in reset while loading. It then releases the CPU through a warm-up window and runs it until halt or a cycle limit, and finally streams a RAM window back out.
- It sits between a host byte channel and the `ram`/`CPU` pair, replacing file preload, fixed warm-up loops and end-of-run dumps with one parametrised block.

## Interface
Parameters:
- ADDR_W, 8, RAM byte-address width.
- WORD_BYTES, 4, bytes per instruction word; load images are padded to this alignment.
- WARMUP_CYC, 4, cycles after CPU release during which `cpu_halt` is ignored.
- RUN_MAX, 1024, maximum RUN cycles before forced stop.
- DUMP_BASE, 0, first dumped byte address.
- DUMP_LEN, 256, bytes dumped (1..2^ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset; one clock, asynchronous, active-low.
- start  in  1  begin a load/run/dump sequence; honoured only in IDLE or DONE.
- ld_valid  in  1  load byte valid.
- ld_ready  out  1  load byte accepted.
- ld_data  in  8  load byte; first byte goes to address 0 (word MSB first).
- ld_last  in  1  final image byte, qualified by handshake.
- mem_we  out  1  RAM byte write strobe.
- mem_addr  out  ADDR_W  RAM byte address.
- mem_wdata  out  8  RAM write byte.
- mem_rdata  in  8  RAM read byte; valid one cycle after `mem_addr`.
- cpu_run  out  1  1 = CPU out of reset and clocked through.
- cpu_halt  in  1  CPU reports no valid instruction.
- dp_valid  out  1  dump byte valid.
- dp_ready  in  1  dump byte accepted.
- dp_data  out  8  dump byte.
- dp_last  out  1  final dump byte.
- busy  out  1  state not IDLE/DONE.
- done  out  1  level, high in DONE.
- timeout  out  1  sticky; RUN ended by RUN_MAX.
- overflow  out  1  sticky; image exceeded 2^ADDR_W bytes.
- word_count  out  ADDR_W  words written, including a padded final word.

## Operation
- States: IDLE, LOAD, PAD, WARMUP, RUN, DUMP_RD, DUMP_TX, DONE.
- IDLE/DONE → LOAD on `start`. Entering LOAD clears the pointer, `word_count`, `timeout` and `overflow`.
- LOAD:
  - `ld_ready`=1.
  - Each handshake writes the byte at the pointer, then increments the pointer.
  - Handshake with `ld_last` or at pointer 2^ADDR_W−1 ends LOAD. The second case sets `overflow`; any further bytes are not accepted.
  - End: if the pointer is aligned, go to WARMUP; else go to PAD.
- PAD: writes 0x00 one byte per cycle until the pointer is a multiple of WORD_BYTES, then goes to WARMUP. `ld_ready`=0.
- `word_count` increments when a write lands on byte WORD_BYTES−1 of a word.
- WARMUP: `cpu_run`=1; after WARMUP_CYC cycles → RUN.
- RUN:
  - `cpu_run`=1; the cycle counter increments each cycle.
  - `cpu_halt` → DUMP_RD.
  - Counter = RUN_MAX−1 without halt → set `timeout`, then DUMP_RD.
  - Halt in the same cycle takes priority; `timeout` stays 0.
- DUMP_RD: drive `mem_addr` = DUMP_BASE+index (modulo 2^ADDR_W) → DUMP_TX.
- DUMP_TX:
  - Capture `mem_rdata` into `dp_data`; hold `dp_valid`=1 and the data stable until `dp_ready`.
  - `dp_last`=1 on index DUMP_LEN−1.
  - On handshake: index++, back to DUMP_RD, or DONE after the last byte.
- `start` outside IDLE/DONE is ignored.
- `cpu_run`=0 in every state except WARMUP/RUN.

## Timing
- Reset (`clr` low) is immediate, including mid-sequence. All outputs go to 0: `mem_addr`=0, `dp_data`=0, `word_count`=0, flags 0. State goes to IDLE.
- `start` at edge n → LOAD at n+1 (`ld_ready` high from cycle n+1).
- RAM writes are registered: a handshake at edge n gives `mem_we`=1 with addr/data during cycle n+1.
- Load throughput is 1 byte/cycle. PAD adds up to WORD_BYTES−1 cycles.
- WARMUP lasts exactly WARMUP_CYC cycles. RUN lasts at most RUN_MAX cycles.
- Dump throughput is at most 1 byte per 2 cycles. First `dp_valid` is 2 cycles after leaving RUN.
- `ld_valid` with `ld_ready`=0 is simply not consumed; no data loss.

## Structure
- Shared package `prog_ctrl_pkg` holds the state encoding localparams and default parameter values; the CPU bench imports it.
- One sub-module, `dump_out_reg`: the valid/ready holding register for `dp_data`/`dp_last`. Counters and FSM stay in the top.

## Test plan
- Load 8 bytes 0xE3,0xA0,0x10,0x04,0xE2,0x81,0x10,0x08 (last on the 8th), halt after 10 RUN cycles. Required: RAM[0..7] matches; `word_count`=2; `cpu_run` high for 4+10 cycles; 256 bytes dumped; `dp_last` only on the 256th; `done`=1.
- Load 6 bytes. Required: PAD writes 0x00 to addresses 6 and 7; `word_count`=2.
- Never assert halt, RUN_MAX=16. Required: `timeout`=1 after 16 RUN cycles, then the dump proceeds.
- Halt during WARMUP is ignored. Halt coinciding with the RUN_MAX boundary: `timeout`=0.
- 300-byte image with ADDR_W=8. Required: `overflow`=1; `ld_ready` drops after 256 bytes.
- `dp_ready` low for 5 cycles mid-dump. Required: `dp_data` stable. Assert `clr` mid-RUN: all outputs 0, state IDLE.
